// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one serial transmit line
// between NUM_REQ byte requesters. Frame on the line: idle low, start bit high,
// 8 data bits LSB-first, stop bit low, then a low guard gap.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line low, scanning req from rr_ptr upward for the next winner
// START | start bit (line high) for BIT_CYCLES cycles
// DATA  | shift[bit_idx] on the line, BIT_CYCLES cycles per bit, 8 bits
// STOP  | stop bit (line low) for BIT_CYCLES cycles
// GAP   | low guard for GAP_CYCLES cycles, done on the final cycle
//
// tx_line is registered from the current state, so the line trails the state
// by one cycle: ack and the first START cycle coincide, and the line rises on
// the cycle after ack.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BIT_CYCLES = 10_000_000,
  parameter int GAP_CYCLES = 20_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_line
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(BIT_CYCLES);
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic [BC_W-1:0] bit_cnt;
  logic [GC_W-1:0] gap_cnt;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] rr_next;
  logic            bit_last;
  logic            gap_last;
  logic            gap_pre_last;
  logic            line_now;

  assign bit_last     = (bit_cnt == BC_W'(BIT_CYCLES - 1));
  assign gap_last     = (gap_cnt == GC_W'(GAP_CYCLES - 1));
  // done is registered, so it is armed one cycle before the final gap cycle
  assign gap_pre_last = (GAP_CYCLES >= 2) && (gap_cnt == GC_W'(GAP_CYCLES - 2));
  assign rr_next      = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + 1'b1;

  // Round-robin pick: first set req scanning upward from rr_ptr with wrap.
  // The loop runs from the farthest candidate down so the nearest one wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Line level implied by the current state; registered below.
  always_comb begin
    line_now = 1'b0;
    case (state)
      S_START: line_now = 1'b1;
      S_DATA:  line_now = shift[bit_idx];
      default: line_now = 1'b0;
    endcase
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ack      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      tx_line  <= 1'b0;
    end else begin
      ack     <= '0;
      done    <= 1'b0;
      tx_line <= line_now;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            ack      <= NUM_REQ'(1) << pick_id;
            shift    <= req_data[{pick_id, 3'b000} +: 8];
            grant_id <= pick_id;
            rr_ptr   <= rr_next;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
            // a one-cycle gap is its own final cycle
            if (GAP_CYCLES == 1) begin
              done <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_last) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_pre_last) begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with BIT_CYCLES=4, GAP_CYCLES=8, NUM_REQ=4.
// Stimulus pushes the expected (requester, byte) for each grant; the monitor
// pops on every ack, decodes the frame from tx_line and checks framing, byte,
// grant_id and done timing.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int BIT_CYCLES = 4;
  localparam int GAP_CYCLES = 8;
  // ack-relative offsets: line rises at +1, data bit k centred at +6+4k,
  // stop bit at +38, done on the final gap cycle at +47, next ack at +49
  localparam int DONE_OFF   = 10 * BIT_CYCLES + GAP_CYCLES - 1;
  localparam int ACK_PERIOD = 10 * BIT_CYCLES + GAP_CYCLES + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 done;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 tx_line;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   failed   = 0;
  int   cyc      = 0;
  int   ack1_cnt = 0;

  logic       in_frame = 1'b0;
  int         off      = 0;
  exp_t       cur;
  logic [7:0] rx;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .BIT_CYCLES(BIT_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .done(done),
    .busy(busy),
    .grant_id(grant_id),
    .tx_line(tx_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each ack and follows the frame on the line.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (done) chk("done_outside_frame", 32'(done), 32'd0);
      if (ack != '0) begin
        if (ack[1]) ack1_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'd1 << cur.id);
          chk("grant_id", 32'(grant_id), 32'(cur.id));
          in_frame = 1'b1;
          off      = 0;
          rx       = 8'h00;
        end
      end
    end else begin
      off = off + 1;
      if (ack != '0) chk("ack_during_frame", 32'(ack), 32'd0);
      if (off == 1) chk("busy_in_frame", 32'(busy), 32'd1);
      if (off == 2) chk("start_bit", 32'(tx_line), 32'd1);
      if (off >= 6 && off <= 34 && ((off - 6) % 4 == 0)) rx[(off - 6) / 4] = tx_line;
      if (off == 38) chk("stop_bit", 32'(tx_line), 32'd0);
      if (off == 44) chk("gap_low", 32'(tx_line), 32'd0);
      if (done && off != DONE_OFF) chk("done_offset", 32'(off), 32'(DONE_OFF));
      if (off == DONE_OFF) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("rx_byte", 32'(rx), 32'(cur.data));
        chk("grant_hold", 32'(grant_id), 32'(cur.id));
        in_frame = 1'b0;
      end
    end
  end

  task automatic wait_ack(input int idx, output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ack[idx]) begin
        at = cyc;
        break;
      end
    end
    chk($sformatf("ack%0d_seen", idx), 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && !in_frame && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("return_idle", 32'(ok), 32'd1);
  endtask

  task automatic push_req(input int idx, input logic [7:0] data);
    exp_t e;
    e.id   = idx;
    e.data = data;
    exp_q.push_back(e);
    req_data[idx*8 +: 8] = data;
    req[idx] = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int prev;
    int base1;
    logic seen_done;
    int order [5] = '{0, 1, 2, 3, 0};

    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_line", 32'(tx_line), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;

    // single request on requester 1
    @(posedge clk); #1;
    push_req(1, 8'hA5);
    wait_ack(1, t);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_idle();

    // fairness: all requesters held high from a fresh pointer
    pulse_reset();
    req_data = {8'h88, 8'h44, 8'h22, 8'h11};
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.id   = order[k];
      e.data = req_data[order[k]*8 +: 8];
      exp_q.push_back(e);
    end
    req  = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(order[k], t);
      if (k > 0) chk("ack_spacing", 32'(t - prev), 32'(ACK_PERIOD));
      prev = t;
    end
    @(posedge clk); #1;
    req = '0;
    wait_idle();

    // pointer wrap: serve 3, then 0 and 2 raised together go 0 then 2
    @(posedge clk); #1;
    push_req(3, 8'hC3);
    wait_ack(3, t);
    @(posedge clk); #1;
    req[3] = 1'b0;
    push_req(0, 8'h0F);
    push_req(2, 8'hF0);
    wait_ack(0, t);
    @(posedge clk); #1;
    req[0] = 1'b0;
    wait_ack(2, t);
    @(posedge clk); #1;
    req[2] = 1'b0;
    wait_idle();

    // latched byte immune to req_data change after ack
    @(posedge clk); #1;
    push_req(0, 8'h3C);
    wait_ack(0, t);
    @(posedge clk); #1;
    req_data[7:0] = 8'hFF;
    req[0] = 1'b0;
    wait_idle();

    // reset in the middle of data bit 3
    @(posedge clk); #1;
    push_req(1, 8'h5A);
    wait_ack(1, t);
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_line", 32'(tx_line), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("no_done_after_reset", 32'(seen_done), 32'd0);
    @(posedge clk); #1;
    push_req(2, 8'h01);
    wait_ack(2, t);
    @(posedge clk); #1;
    req[2] = 1'b0;
    wait_idle();

    // requester 1 pulses for one cycle while busy: withdrawn, never acked
    base1 = ack1_cnt;
    @(posedge clk); #1;
    push_req(0, 8'h96);
    wait_ack(0, t);
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    req_data[15:8] = 8'h77;
    req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("withdrawn_no_ack1", 32'(ack1_cnt - base1), 32'd0);
    chk("withdrawn_idle_busy", 32'(busy), 32'd0);
    chk("withdrawn_idle_line", 32'(tx_line), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
